lq_tagged_queue: RTL and testbench

- Parametrised, in-order-retiring load queue between dispatch and the memory bus.
- Stages per entry: allocate in program order, issue the oldest unissued entry to memory, capture out-of-order responses by memory tag, retire from head once data has returned.
- Exact occupancy counter, so all DEPTH entries are usable.
- Adds an explicit issue stage, data capture, flush and occupancy reporting.

---
 rtl/lq_tagged_queue.sv | 127 ++++++++++++
 tb/tb_lq_tagged_queue.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lq_tagged_queue.sv
// In-order load queue: allocate at tail, issue oldest unissued entry, capture tagged
// responses out of order, retire from head. Outputs are registered-state only; alloc stalls when full.
module lq_tagged_queue #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int REG_W  = 6
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     alloc_valid,
  input  logic [ADDR_W-1:0]        alloc_addr,
  input  logic [REG_W-1:0]         alloc_dest,
  output logic                     alloc_ready,
  output logic                     mem_req_valid,
  output logic [ADDR_W-1:0]        mem_req_addr,
  input  logic [TAG_W-1:0]         mem_req_tag,
  input  logic [TAG_W-1:0]         mem_resp_tag,
  input  logic [DATA_W-1:0]        mem_resp_data,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [REG_W-1:0]         out_dest,
  input  logic                     out_pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]  ent_valid;
  logic [DEPTH-1:0]  ent_issued;
  logic [DEPTH-1:0]  ent_done;
  logic [ADDR_W-1:0] ent_addr [DEPTH];
  logic [REG_W-1:0]  ent_dest [DEPTH];
  logic [TAG_W-1:0]  ent_tag  [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] issue_ptr;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] occ;

  logic             alloc_fire;
  logic             issue_fire;
  logic             pop_fire;
  logic             resp_hit;
  logic [PTR_W-1:0] resp_idx;
  logic [PTR_W-1:0] scan_idx;

  assign alloc_ready   = occ < CNT_W'(DEPTH);
  assign mem_req_valid = ent_valid[issue_ptr] && !ent_issued[issue_ptr];
  assign mem_req_addr  = ent_addr[issue_ptr];
  assign out_valid     = ent_valid[head] && ent_done[head];
  assign out_data      = ent_data[head];
  assign out_dest      = ent_dest[head];
  assign count         = occ;
  assign empty         = (occ == '0);

  assign alloc_fire = alloc_valid && alloc_ready;
  assign issue_fire = mem_req_valid && (mem_req_tag != '0);
  assign pop_fire   = out_pop && out_valid;

  // Scan from youngest to oldest so the entry nearest head is the last writer.
  always_comb begin
    resp_hit = 1'b0;
    resp_idx = head;
    scan_idx = head;
    if (mem_resp_tag != '0) begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        scan_idx = head + PTR_W'(i);
        if (ent_valid[scan_idx] && ent_issued[scan_idx] && !ent_done[scan_idx] &&
            (ent_tag[scan_idx] == mem_resp_tag)) begin
          resp_hit = 1'b1;
          resp_idx = scan_idx;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      ent_valid  <= '0;
      ent_issued <= '0;
      ent_done   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_tag[i] <= '0;
      end
      head      <= '0;
      issue_ptr <= '0;
      tail      <= '0;
      occ       <= '0;
    end else begin
      if (alloc_fire) begin
        ent_valid[tail]  <= 1'b1;
        ent_issued[tail] <= 1'b0;
        ent_done[tail]   <= 1'b0;
        ent_addr[tail]   <= alloc_addr;
        ent_dest[tail]   <= alloc_dest;
        tail             <= tail + PTR_W'(1);
      end
      if (issue_fire) begin
        ent_tag[issue_ptr]    <= mem_req_tag;
        ent_issued[issue_ptr] <= 1'b1;
        issue_ptr             <= issue_ptr + PTR_W'(1);
      end
      if (resp_hit) begin
        ent_data[resp_idx] <= mem_resp_data;
        ent_done[resp_idx] <= 1'b1;
      end
      if (pop_fire) begin
        ent_valid[head]  <= 1'b0;
        ent_issued[head] <= 1'b0;
        ent_done[head]   <= 1'b0;
        head             <= head + PTR_W'(1);
      end
      case ({alloc_fire, pop_fire})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_lq_tagged_queue.sv
// Directed plus randomised scoreboard bench for lq_tagged_queue with a small tagged memory model.
`timescale 1ns/1ps
module tb_lq_tagged_queue;

  localparam int DEPTH  = 8;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 64;
  localparam int REG_W  = 6;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clock = 1'b0;
  logic              reset;
  logic              flush;
  logic              alloc_valid;
  logic [ADDR_W-1:0] alloc_addr;
  logic [REG_W-1:0]  alloc_dest;
  logic              alloc_ready;
  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [TAG_W-1:0]  mem_req_tag;
  logic [TAG_W-1:0]  mem_resp_tag;
  logic [DATA_W-1:0] mem_resp_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [REG_W-1:0]  out_dest;
  logic              out_pop;
  logic [CNT_W-1:0]  count;
  logic              empty;

  lq_tagged_queue #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .alloc_dest(alloc_dest),
    .alloc_ready(alloc_ready),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_resp_tag(mem_resp_tag), .mem_resp_data(mem_resp_data),
    .out_valid(out_valid), .out_data(out_data), .out_dest(out_dest), .out_pop(out_pop),
    .count(count), .empty(empty)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] data;
  } exp_t;

  int                checks = 0;
  int                errors = 0;
  exp_t              sb[$];
  logic [DATA_W-1:0] mem_img [logic [ADDR_W-1:0]];
  logic [ADDR_W-1:0] tag_addr [16];
  bit                tag_busy [16];

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    flush         = 1'b0;
    alloc_valid   = 1'b0;
    mem_req_tag   = '0;
    mem_resp_tag  = '0;
    mem_resp_data = '0;
    out_pop       = 1'b0;
  endtask

  // Call before pop_chk in a cycle: a pop never frees space for a same-cycle allocate.
  task automatic do_alloc(input logic [ADDR_W-1:0] a, input logic [REG_W-1:0] d,
                          input logic [DATA_W-1:0] v);
    exp_t e;
    alloc_valid = 1'b1;
    alloc_addr  = a;
    alloc_dest  = d;
    if (sb.size() < DEPTH) begin
      e.dest = d;
      e.data = v;
      sb.push_back(e);
      mem_img[a] = v;
    end
  endtask

  task automatic issue(input logic [TAG_W-1:0] t);
    mem_req_tag = t;
    if (mem_req_valid) begin
      tag_addr[t] = mem_req_addr;
      tag_busy[t] = 1'b1;
    end
  endtask

  task automatic resp(input logic [TAG_W-1:0] t);
    mem_resp_tag  = t;
    mem_resp_data = mem_img.exists(tag_addr[t]) ? mem_img[tag_addr[t]] : '0;
    tag_busy[t]   = 1'b0;
  endtask

  task automatic pop_chk(input string name);
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    if (out_valid) begin
      if (sb.size() > 0) begin
        chk({name, "_data"}, out_data, sb[0].data);
        chk({name, "_dest"}, 64'(out_dest), 64'(sb[0].dest));
        void'(sb.pop_front());
      end else begin
        chk({name, "_sb_depth"}, 64'(sb.size()), 64'd1);
      end
    end
    out_pop = 1'b1;
  endtask

  // Randomised traffic: allocate n_alloc loads, issue with stalls, respond out of order, drain.
  task automatic run(input int n_alloc, input int max_cycles, input logic [ADDR_W-1:0] base);
    int sent;
    int cyc;
    int s;
    int t;
    logic [TAG_W-1:0] r;
    logic [TAG_W-1:0] q;
    sent = 0;
    cyc  = 0;
    while ((sent < n_alloc || sb.size() > 0) && cyc < max_cycles) begin
      idle();
      chk("occupancy", 64'(count), 64'(sb.size()));
      if (sent < n_alloc && sb.size() < DEPTH && $urandom_range(3) != 0) begin
        do_alloc(base + 64'(sent) * 64'd16, REG_W'(sent), {$urandom, $urandom});
        sent++;
      end
      r = '0;
      if ($urandom_range(1) != 0) begin
        s = int'($urandom_range(14));
        for (int k = 0; k < 15; k++) begin
          t = 1 + (s + k) % 15;
          if (tag_busy[t] && r == '0) r = TAG_W'(t);
        end
      end
      q = '0;
      if (mem_req_valid && $urandom_range(3) != 0) begin
        for (int k = 1; k < 16; k++) begin
          if (!tag_busy[k] && q == '0) q = TAG_W'(k);
        end
      end
      if (q != '0) issue(q);
      if (r != '0) resp(r);
      if (out_valid && $urandom_range(3) != 0) pop_chk("run_pop");
      tick();
      cyc++;
    end
    chk("run_drained", 64'(sb.size()), 64'd0);
    chk("run_count", 64'(count), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      tag_busy[i] = 1'b0;
      tag_addr[i] = '0;
    end
    idle();
    alloc_addr = '0;
    alloc_dest = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_count", 64'(count), 64'd0);

    // Fill to DEPTH with memory refusing every request, then try one more.
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      do_alloc(64'h1000 + 64'(i) * 64'd16, REG_W'(i), 64'hF000 + 64'(i));
      tick();
    end
    chk("full_count", 64'(count), 64'd8);
    chk("full_alloc_ready", 64'(alloc_ready), 64'd0);
    chk("full_empty", 64'(empty), 64'd0);
    idle();
    do_alloc(64'h2000, 6'd9, 64'hDEAD);
    tick();
    chk("ninth_ignored", 64'(count), 64'd8);
    run(0, 300, 64'h0);

    // Out-of-order responses, in-order retire.
    idle();
    do_alloc(64'h100, 6'd1, 64'hAA);
    tick();
    chk("a_req_addr", mem_req_addr, 64'h100);
    idle();
    issue(TAG_W'(3));
    do_alloc(64'h200, 6'd2, 64'hBB);
    tick();
    chk("b_req_addr", mem_req_addr, 64'h200);
    idle();
    issue(TAG_W'(5));
    tick();
    chk("ab_issued", 64'(mem_req_valid), 64'd0);
    idle();
    resp(TAG_W'(5));
    tick();
    chk("b_done_head_wait", 64'(out_valid), 64'd0);
    idle();
    resp(TAG_W'(3));
    tick();
    idle();
    pop_chk("pop_a");
    tick();
    idle();
    pop_chk("pop_b");
    tick();
    chk("ab_empty", 64'(empty), 64'd1);

    // Issue stall: address holds while memory returns tag 0.
    idle();
    do_alloc(64'h300, 6'd3, 64'hCC);
    tick();
    for (int k = 0; k < 3; k++) begin
      idle();
      chk("stall_req_valid", 64'(mem_req_valid), 64'd1);
      chk("stall_req_addr", mem_req_addr, 64'h300);
      tick();
    end
    idle();
    issue(TAG_W'(2));
    tick();
    chk("stall_issued_once", 64'(mem_req_valid), 64'd0);
    idle();
    resp(TAG_W'(2));
    tick();
    idle();
    pop_chk("stall_pop");
    tick();
    idle();
    resp(TAG_W'(2));
    tick();
    chk("stale_resp_out_valid", 64'(out_valid), 64'd0);
    chk("stale_resp_count", 64'(count), 64'd0);

    // Full queue with head done: pop wins, allocate is refused that cycle.
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      do_alloc(64'h400 + 64'(i) * 64'd16, REG_W'(i), 64'h5000 + 64'(i));
      tick();
    end
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      issue(TAG_W'(i + 1));
      tick();
    end
    idle();
    resp(TAG_W'(1));
    tick();
    chk("fp_count_full", 64'(count), 64'd8);
    chk("fp_head_done", 64'(out_valid), 64'd1);
    idle();
    do_alloc(64'h600, 6'd20, 64'h6000);
    resp(TAG_W'(2));
    pop_chk("fp_pop0");
    tick();
    chk("fp_count_after_pop", 64'(count), 64'd7);
    chk("fp_ready_after_pop", 64'(alloc_ready), 64'd1);
    idle();
    do_alloc(64'h610, 6'd21, 64'h6100);
    pop_chk("fp_pop1");
    tick();
    chk("fp_alloc_pop_count", 64'(count), 64'd7);
    idle();
    do_alloc(64'h620, 6'd22, 64'h6200);
    tick();
    chk("fp_refill_count", 64'(count), 64'd8);
    chk("fp_refill_ready", 64'(alloc_ready), 64'd0);
    run(0, 300, 64'h0);

    // Pointer wrap-around under mixed traffic.
    run(20, 2000, 64'h8000);
    run(40, 3000, 64'h20000);

    // Flush with five entries, three issued; a concurrent allocate is discarded too.
    for (int i = 0; i < 5; i++) begin
      idle();
      do_alloc(64'h900 + 64'(i) * 64'd16, REG_W'(i), 64'h9000 + 64'(i));
      if (i >= 1 && i <= 3) issue(TAG_W'(i));
      tick();
    end
    chk("pre_flush_count", 64'(count), 64'd5);
    idle();
    flush       = 1'b1;
    alloc_valid = 1'b1;
    alloc_addr  = 64'hDEAD;
    tick();
    sb.delete();
    for (int i = 0; i < 16; i++) tag_busy[i] = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_empty", 64'(empty), 64'd1);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_req_valid", 64'(mem_req_valid), 64'd0);
    idle();
    resp(TAG_W'(2));
    tick();
    chk("flushed_resp_out_valid", 64'(out_valid), 64'd0);
    chk("flushed_resp_count", 64'(count), 64'd0);
    idle();
    do_alloc(64'hA00, 6'd7, 64'hA0A0);
    tick();
    chk("post_flush_req_valid", 64'(mem_req_valid), 64'd1);
    chk("post_flush_req_addr", mem_req_addr, 64'hA00);
    chk("post_flush_count", 64'(count), 64'd1);
    run(0, 100, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
